// File: rtl/prco_lmem_arb_pkg.sv
// prco_lmem_arb_pkg: channel indices, default geometry and channel state type
// shared by the local-memory arbiter, its round-robin sub-block and the bus interface.
package prco_lmem_arb_pkg;

    localparam int LMEM_CH_IF  = 0;
    localparam int LMEM_CH_D   = 1;

    localparam int LMEM_DATA_W = 16;
    localparam int LMEM_ADDR_W = 16;
    localparam int LMEM_DEPTH  = 256;

    typedef enum logic {
        CH_IDLE,
        CH_ACK
    } ch_state_e;

endpackage

// File: rtl/prco_lmem_arb_if.sv
// prco_lmem_arb_if: fetch and load/store req/ack channels of the local memory.
// q_err exists only when PRCO_LMEM_BOUNDS_EN is defined.
interface prco_lmem_arb_if #(
    parameter int P_DATA_W = 16,
    parameter int P_ADDR_W = 16
);

    logic                  i_if_req;
    logic [P_ADDR_W-1:0]   i_if_addr;
    logic                  q_if_ack;
    logic [P_DATA_W-1:0]   q_if_data;

    logic                  i_d_req;
    logic                  i_d_we;
    logic [P_DATA_W/8-1:0] i_d_be;
    logic [P_ADDR_W-1:0]   i_d_addr;
    logic [P_DATA_W-1:0]   i_d_wdata;
    logic                  q_d_ack;
    logic [P_DATA_W-1:0]   q_d_rdata;
`ifdef PRCO_LMEM_BOUNDS_EN
    logic                  q_err;
`endif

    modport master (
        output i_if_req, i_if_addr,
        input  q_if_ack, q_if_data,
        output i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        input  q_d_ack, q_d_rdata
`ifdef PRCO_LMEM_BOUNDS_EN
        , input q_err
`endif
    );

    modport slave (
        input  i_if_req, i_if_addr,
        output q_if_ack, q_if_data,
        input  i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata,
        output q_d_ack, q_d_rdata
`ifdef PRCO_LMEM_BOUNDS_EN
        , output q_err
`endif
    );

endinterface

// File: rtl/prco_lmem_rr2.sv
// prco_lmem_rr2: two-way round-robin arbiter; last_d remembers whether the
// data channel won the most recent contested grant.
module prco_lmem_rr2
    import prco_lmem_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_elig,
    output logic [1:0] q_gnt
);

    logic last_d;
    logic contest;

    assign contest = &i_elig;

    always_comb begin
        q_gnt = i_elig;
        if (contest) begin
            q_gnt[LMEM_CH_D]  = ~last_d;
            q_gnt[LMEM_CH_IF] = last_d;
        end
    end

    // Uncontested grants leave the fairness history untouched.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            last_d <= 1'b0;
        else if (contest)
            last_d <= q_gnt[LMEM_CH_D];
    end

endmodule

// File: rtl/prco_lmem_arb.sv
// prco_lmem_arb: single-port local memory shared by fetch and load/store channels.
// Define PRCO_LMEM_BOUNDS_EN for range checking (q_err) and arbitrary P_DEPTH.
module prco_lmem_arb
    import prco_lmem_arb_pkg::*;
#(
    parameter int P_DATA_W = LMEM_DATA_W,
    parameter int P_ADDR_W = LMEM_ADDR_W,
    parameter int P_DEPTH  = LMEM_DEPTH
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    prco_lmem_arb_if.slave bus
);

    localparam int NB = P_DATA_W / 8;
    localparam int IW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    ch_state_e           if_st, if_nx;
    ch_state_e           d_st, d_nx;
    logic [1:0]          elig;
    logic [1:0]          gnt;
    logic [P_DATA_W-1:0] mem [P_DEPTH];
    logic [IW-1:0]       if_idx, d_idx;
    logic                if_ok, d_ok;
    logic [P_DATA_W-1:0] if_data_q, d_rdata_q;

    if (P_DATA_W % 8 != 0) begin : g_bad_width
        $error("P_DATA_W must be a multiple of 8");
    end

    assign if_idx = bus.i_if_addr[IW-1:0];
    assign d_idx  = bus.i_d_addr[IW-1:0];

`ifdef PRCO_LMEM_BOUNDS_EN
    localparam logic [P_ADDR_W:0] DEPTH_A = (P_ADDR_W+1)'(P_DEPTH);

    if (P_DEPTH < 2) begin : g_bad_depth
        $error("P_DEPTH must be at least 2");
    end

    assign if_ok = {1'b0, bus.i_if_addr} < DEPTH_A;
    assign d_ok  = {1'b0, bus.i_d_addr} < DEPTH_A;
`else
    logic unused_hi;

    if ((1 << IW) != P_DEPTH) begin : g_bad_depth
        $error("P_DEPTH must be a power of two");
    end

    // Upper address bits are dropped so the array wraps.
    assign unused_hi = ^{bus.i_if_addr, bus.i_d_addr};
    assign if_ok = 1'b1;
    assign d_ok  = 1'b1;
`endif

    assign elig[LMEM_CH_IF] = bus.i_if_req && (if_st == CH_IDLE);
    assign elig[LMEM_CH_D]  = bus.i_d_req && (d_st == CH_IDLE);

    prco_lmem_rr2 u_rr (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_elig    (elig),
        .q_gnt     (gnt)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            if_st <= CH_IDLE;
            d_st  <= CH_IDLE;
        end else begin
            if_st <= if_nx;
            d_st  <= d_nx;
        end
    end

    always_comb begin
        if_nx = CH_IDLE;
        d_nx  = CH_IDLE;
        if (gnt[LMEM_CH_IF])
            if_nx = CH_ACK;
        if (gnt[LMEM_CH_D])
            d_nx = CH_ACK;
    end

    assign bus.q_if_ack = (if_st == CH_ACK);
    assign bus.q_d_ack  = (d_st == CH_ACK);

    // The array has no reset; writes are blocked while reset is held.
    always_ff @(posedge i_clk) begin
        if (i_reset_n && gnt[LMEM_CH_D] && bus.i_d_we && d_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.i_d_be[b])
                    mem[d_idx][b*8 +: 8] <= bus.i_d_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (gnt[LMEM_CH_IF])
                if_data_q <= if_ok ? mem[if_idx] : '0;
            if (gnt[LMEM_CH_D] && !bus.i_d_we)
                d_rdata_q <= d_ok ? mem[d_idx] : '0;
        end
    end

    assign bus.q_if_data = if_data_q;
    assign bus.q_d_rdata = d_rdata_q;

`ifdef PRCO_LMEM_BOUNDS_EN
    logic err_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            err_q <= 1'b0;
        else
            err_q <= (gnt[LMEM_CH_IF] && !if_ok) || (gnt[LMEM_CH_D] && !d_ok);
    end

    assign bus.q_err = err_q;
`endif

endmodule

// File: tb/tb_prco_lmem_arb.sv
// tb_prco_lmem_arb: directed and randomized checks of prco_lmem_arb against a
// word-array model and the alternate-on-contest fairness rule.
module tb_prco_lmem_arb;

    localparam int DW = 16;
    localparam int AW = 16;
`ifdef PRCO_LMEM_BOUNDS_EN
    localparam int DEPTH = 200;
`else
    localparam int DEPTH = 256;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prco_lmem_arb_if #(.P_DATA_W(DW), .P_ADDR_W(AW)) bus ();

    prco_lmem_arb #(
        .P_DATA_W (DW),
        .P_ADDR_W (AW),
        .P_DEPTH  (DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] model [DEPTH];
    bit          known [DEPTH];
    bit          last_was_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [15:0] a);
`ifdef PRCO_LMEM_BOUNDS_EN
        return int'(a) < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = wd[7:0];
        if (be[1]) r[15:8] = wd[15:8];
        return r;
    endfunction

    task automatic d_op(input bit we, input logic [1:0] be, input logic [15:0] a,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output int lat, output bit err);
        bit got;
        bus.i_d_req   = 1'b1;
        bus.i_d_we    = we;
        bus.i_d_be    = be;
        bus.i_d_addr  = a;
        bus.i_d_wdata = wd;
        lat = 0;
        got = 1'b0;
        err = 1'b0;
        rd  = 'x;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.q_d_ack) begin
                got = 1'b1;
                rd  = bus.q_d_rdata;
`ifdef PRCO_LMEM_BOUNDS_EN
                err = bus.q_err;
`endif
            end
        end
        bus.i_d_req = 1'b0;
        chk("d_ack_seen", got, 1);
        @(negedge clk);
        chk("d_ack_pulse", bus.q_d_ack, 0);
    endtask

    task automatic mwrite(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] be);
        logic [15:0] pre, rd;
        int lat, idx;
        bit e;
        pre = bus.q_d_rdata;
        d_op(1'b1, be, a, wd, rd, lat, e);
        chk("wr_latency", lat, 1);
        chk("wr_rdata_hold", rd, pre);
        if (in_range(a)) begin
            idx = int'(a) % DEPTH;
            model[idx] = merge(model[idx], wd, be);
            if (be == 2'b11) known[idx] = 1'b1;
        end
    endtask

    task automatic mread(input logic [15:0] a, output logic [15:0] rd, output bit e);
        int lat, idx;
        d_op(1'b0, 2'b00, a, 16'h0, rd, lat, e);
        chk("rd_latency", lat, 1);
        idx = int'(a) % DEPTH;
        if (!in_range(a))
            chk("rd_oob_zero", rd, 0);
        else if (known[idx])
            chk("rd_data", rd, model[idx]);
    endtask

    task automatic if_wait(output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (bus.q_if_ack) got = 1'b1;
        end
        chk("if_ack_seen", got, 1);
    endtask

    initial begin
        logic [15:0] rd;
        bit e, got;
        int n, cnt_d, cnt_if;

        bus.i_if_req  = 1'b0;
        bus.i_if_addr = '0;
        bus.i_d_req   = 1'b0;
        bus.i_d_we    = 1'b0;
        bus.i_d_be    = '0;
        bus.i_d_addr  = '0;
        bus.i_d_wdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_if_ack", bus.q_if_ack, 0);
        chk("rst_d_ack", bus.q_d_ack, 0);
        chk("rst_if_data", bus.q_if_data, 0);
        chk("rst_d_rdata", bus.q_d_rdata, 0);
`ifdef PRCO_LMEM_BOUNDS_EN
        chk("rst_err", bus.q_err, 0);
`endif
        rst_n = 1'b1;

        // Fetch-only back-to-back reads
        mwrite(16'h0000, 16'h20ab, 2'b11);
        mwrite(16'h0001, 16'h21cd, 2'b11);
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 16'h0000;
        if_wait(n, got);
        chk("if0_latency", n, 1);
        chk("if0_data", bus.q_if_data, 16'h20ab);
        bus.i_if_addr = 16'h0001;
        if_wait(n, got);
        chk("if1_spacing", n, 2);
        chk("if1_data", bus.q_if_data, 16'h21cd);
        bus.i_if_req = 1'b0;
        @(negedge clk);
        chk("if_ack_pulse", bus.q_if_ack, 0);

        // Byte-enabled writes
        mwrite(16'h00aa, 16'hCAFE, 2'b11);
        mread(16'h00aa, rd, e);
        chk("cafe", rd, 16'hCAFE);
        mwrite(16'h00aa, 16'h1234, 2'b01);
        mread(16'h00aa, rd, e);
        chk("be_low", rd, 16'hCA34);
        mwrite(16'h00aa, 16'h5600, 2'b10);
        mread(16'h00aa, rd, e);
        chk("be_high", rd, 16'h5634);

        // be = 0 leaves the word untouched
        mwrite(16'h0010, 16'hBEEF, 2'b11);
        mwrite(16'h0010, 16'h0000, 2'b00);
        mread(16'h0010, rd, e);
        chk("be_zero", rd, 16'hBEEF);

`ifdef PRCO_LMEM_BOUNDS_EN
        mwrite(16'h00C7, 16'h1357, 2'b11);
        mread(16'h00C7, rd, e);
        chk("inrange_err", e, 0);
        mread(16'h00C8, rd, e);
        chk("oob_rd_data", rd, 0);
        chk("oob_rd_err", e, 1);
        mwrite(16'h00C8, 16'hFFFF, 2'b11);
        mread(16'h00C8, rd, e);
        chk("oob_wr_err", e, 1);
        mread(16'h00C7, rd, e);
        chk("oob_neighbour", rd, 16'h1357);
`else
        mwrite(16'h0105, 16'h5A5A, 2'b11);
        mread(16'h0005, rd, e);
        chk("wrap", rd, 16'h5A5A);
`endif

        // Both channels busy from reset: D, IF, D, IF ...
        mwrite(16'h0020, 16'h0D0D, 2'b11);
        mwrite(16'h0021, 16'h0F0F, 2'b11);
        rst_n = 1'b0;
        bus.i_d_req   = 1'b1;
        bus.i_d_we    = 1'b0;
        bus.i_d_addr  = 16'h0020;
        bus.i_if_req  = 1'b1;
        bus.i_if_addr = 16'h0021;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_d = 0;
        cnt_if = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("alt_d", bus.q_d_ack, (k % 2 == 0));
            chk("alt_if", bus.q_if_ack, (k % 2 == 1));
            chk("alt_exclusive", bus.q_d_ack & bus.q_if_ack, 0);
            if (bus.q_d_ack) begin
                cnt_d++;
                chk("alt_d_data", bus.q_d_rdata, 16'h0D0D);
            end
            if (bus.q_if_ack) begin
                cnt_if++;
                chk("alt_if_data", bus.q_if_data, 16'h0F0F);
            end
        end
        chk("alt_cnt_d", cnt_d, 4);
        chk("alt_cnt_if", cnt_if, 4);
        bus.i_d_req  = 1'b0;
        bus.i_if_req = 1'b0;
        @(negedge clk);

        // Fairness history, then reset inside a pending contest
        bus.i_d_req  = 1'b1;
        bus.i_if_req = 1'b1;
        @(negedge clk);
        chk("fair_if", bus.q_if_ack, 1);
        chk("fair_if_d", bus.q_d_ack, 0);
        bus.i_d_req  = 1'b0;
        bus.i_if_req = 1'b0;
        @(negedge clk);
        bus.i_d_req  = 1'b1;
        bus.i_if_req = 1'b1;
        @(negedge clk);
        chk("fair_d", bus.q_d_ack, 1);
        chk("fair_d_if", bus.q_if_ack, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_d_ack", bus.q_d_ack, 0);
        chk("async_if_ack", bus.q_if_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_d", bus.q_d_ack, 1);
        chk("post_rst_if", bus.q_if_ack, 0);
        bus.i_d_req  = 1'b0;
        bus.i_if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        last_was_d = 1'b1;

        // Randomized traffic
        for (int a = 16'h30; a < 16'h40; a++)
            mwrite(16'(a), 16'($urandom), 2'b11);

        for (int it = 0; it < 40; it++) begin
            logic [15:0] da, fa, wd, pre, exp_d, exp_f, got_d, got_f;
            logic [1:0] be;
            bit we, fe, d_first;
            int d_at, f_at;
            da = 16'h30 + 16'($urandom_range(0, 15));
            fa = 16'h30 + 16'((int'(da) - 'h30 + 1 + $urandom_range(0, 14)) % 16);
            wd = 16'($urandom);
            be = 2'($urandom);
            we = 1'($urandom);
            fe = 1'($urandom);
            exp_d = model[int'(da)];
            exp_f = model[int'(fa)];
            pre = bus.q_d_rdata;
            d_at = 0;
            f_at = 0;
            got_d = 'x;
            got_f = 'x;
            bus.i_d_req   = 1'b1;
            bus.i_d_we    = we;
            bus.i_d_be    = be;
            bus.i_d_addr  = da;
            bus.i_d_wdata = wd;
            bus.i_if_req  = fe;
            bus.i_if_addr = fa;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                chk("rnd_exclusive", bus.q_d_ack & bus.q_if_ack, 0);
                if (bus.q_d_ack) begin
                    if (d_at == 0) d_at = c;
                    got_d = bus.q_d_rdata;
                    bus.i_d_req = 1'b0;
                end
                if (bus.q_if_ack) begin
                    if (f_at == 0) f_at = c;
                    got_f = bus.q_if_data;
                    bus.i_if_req = 1'b0;
                end
            end
            bus.i_d_req  = 1'b0;
            bus.i_if_req = 1'b0;
            if (fe) begin
                d_first = !last_was_d;
                last_was_d = d_first;
                chk("rnd_d_slot", d_at, d_first ? 1 : 2);
                chk("rnd_if_slot", f_at, d_first ? 2 : 1);
                chk("rnd_if_data", got_f, exp_f);
            end else begin
                chk("rnd_d_slot", d_at, 1);
                chk("rnd_if_none", f_at, 0);
            end
            if (we) begin
                chk("rnd_wr_hold", got_d, pre);
                model[int'(da)] = merge(model[int'(da)], wd, be);
            end else begin
                chk("rnd_rd_data", got_d, exp_d);
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
